dds: RTL and testbench

Direct digital synthesis core: a phase accumulator steps by a per-cycle frequency word, adds a static phase offset, and maps the resulting phase to sine, triangle and sawtooth samples. It runs in the single system clock domain. It feeds DAC or waveform-output paths that take unsigned, offset-binary samples.

---
 rtl/dds_pkg.sv | 32 +++
 rtl/dds_sine_lut.sv | 51 +++++
 rtl/dds.sv | 71 +++++++
 tb/tb_dds.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared parameters and the elaboration-time sine table builder for the dds core.
// The table is computed from real arithmetic so it follows the width parameters without external files.
package dds_pkg;

    localparam int LUT_AW_DEF    = 10;
    localparam int QTR_DEPTH_DEF = 1 << (LUT_AW_DEF - 2);

    localparam real PI = 3.14159265358979323846;

    // Odd Taylor series; over 0..pi/2 twelve terms are far below one output LSB.
    function automatic real sin_taylor(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Quarter-wave entry k, sampled at bin centres so the folded quadrants mirror cleanly.
    function automatic int sine_entry(input int k, input int out_w, input int lut_aw);
        real x;
        real amp;
        x   = (PI / 2.0) * (k + 0.5) / (1 << (lut_aw - 2));
        amp = (1 << (out_w - 1)) - 1;
        return $rtoi(amp * sin_taylor(x) + 0.5);
    endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Quadrant-folded quarter-wave sine ROM with a registered offset-binary output.
// One clock of latency from phase to wave_sin.
module dds_sine_lut
    import dds_pkg::*;
#(
    parameter int OW     = 12,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LUT_AW-1:0] phase,
    output logic [OW-1:0]     wave_sin
);

    localparam int QA    = LUT_AW - 2;
    localparam int DEPTH = 1 << QA;
    localparam logic [OW-1:0] MID = {1'b1, {(OW-1){1'b0}}};

    logic [OW-1:0] rom [DEPTH];
    logic [1:0]    quad;
    logic [QA-1:0] q;
    logic [QA-1:0] idx;
    logic [OW-1:0] entry;
    logic [OW-1:0] sin_d;
    logic [OW-1:0] sin_q;

    // NOTE: the table is constant logic, not storage, so it has no reset term.
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int ENTRY = sine_entry(k, OW, LUT_AW);
        assign rom[k] = ENTRY[OW-1:0];
    end

    always_comb begin
        quad  = phase[LUT_AW-1 -: 2];
        q     = phase[QA-1:0];
        idx   = quad[0] ? ~q : q;
        entry = rom[idx];
        sin_d = quad[1] ? (MID - entry) : (MID + entry);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sin_q <= MID;
        end else begin
            sin_q <= sin_d;
        end
    end

    assign wave_sin = sin_q;

endmodule

// File: rtl/dds.sv
// Direct digital synthesis top: phase accumulator, phase offset, and sine/triangle/saw outputs.
// All three outputs are registered from the same phase register so they stay cycle-aligned.
module dds
    import dds_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 12,
    parameter int PHASE_WIDTH  = 32,
    parameter int LUT_AW       = LUT_AW_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [PHASE_WIDTH-1:0]  fre_word,
    input  logic [PHASE_WIDTH-1:0]  pha_word,
    output logic [OUTPUT_WIDTH-1:0] wave_sin,
    output logic [OUTPUT_WIDTH-1:0] wave_tri,
    output logic [OUTPUT_WIDTH-1:0] wave_saw
);

    localparam int OW = OUTPUT_WIDTH;
    localparam int PW = PHASE_WIDTH;

    logic [PW-1:0] acc_d, acc_q;
    logic [PW-1:0] ph_d,  ph_q;
    logic [OW-1:0] saw_d, saw_q;
    logic [OW-1:0] tri_d, tri_q;
    logic [OW-1:0] tri_p;

    always_comb begin
        acc_d = acc_q + fre_word;
        ph_d  = acc_q + pha_word;
        saw_d = ph_q[PW-1 -: OW];
        tri_p = ph_q[PW-2 -: OW];
        tri_d = ph_q[PW-1] ? ~tri_p : tri_p;
    end

    // NOTE: non-blocking assignments let every register sample the pre-edge values,
    // which is what gives ph the old acc and the outputs the old ph.
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_q <= '0;
            ph_q  <= '0;
            saw_q <= '0;
            tri_q <= '0;
        end else begin
            acc_q <= acc_d;
            ph_q  <= ph_d;
            saw_q <= saw_d;
            tri_q <= tri_d;
        end
    end

    dds_sine_lut #(
        .OW     (OW),
        .LUT_AW (LUT_AW)
    ) u_sine (
        .clock    (clock),
        .reset    (reset),
        .phase    (ph_q[PW-1 -: LUT_AW]),
        .wave_sin (wave_sin)
    );

    // Phase bits below the triangle slice are deliberately truncated.
    if (PW - OW - 1 > 0) begin : g_trunc
        logic unused_ph_lsbs;
        assign unused_ph_lsbs = ^ph_q[PW-OW-2:0];
    end

    assign wave_saw = saw_q;
    assign wave_tri = tri_q;

endmodule

// File: tb/tb_dds.sv
// Scoreboard bench for dds: the driver pushes model predictions, a monitor compares each cycle.
// The model works on whole phase values with plain arithmetic and $sin.
module tb_dds;

    localparam int OW = 12;
    localparam int PW = 32;
    localparam real PI = 3.14159265358979323846;
    localparam longint unsigned MOD = 64'h1_0000_0000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [PW-1:0] fre_word = '0;
    logic [PW-1:0] pha_word = '0;
    logic [OW-1:0] wave_sin;
    logic [OW-1:0] wave_tri;
    logic [OW-1:0] wave_saw;

    dds #(
        .OUTPUT_WIDTH (OW),
        .PHASE_WIDTH  (PW),
        .LUT_AW       (10)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .fre_word (fre_word),
        .pha_word (pha_word),
        .wave_sin (wave_sin),
        .wave_tri (wave_tri),
        .wave_saw (wave_saw)
    );

    always #5 clock = ~clock;

    typedef struct {
        int    sin_v;
        int    tri_v;
        int    saw_v;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    longint unsigned m_acc = 0;
    longint unsigned m_ph  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waveforms as functions of the full phase value (fraction of a turn = ph / 2^32).
    function automatic exp_t wave_of(input longint unsigned ph, input string tag);
        exp_t e;
        int   i;
        real  v;
        e.tag   = tag;
        e.saw_v = int'(ph / (64'd1 << 20));
        if (ph < 64'h8000_0000) e.tri_v = int'(ph / (64'd1 << 19));
        else                    e.tri_v = int'((MOD - 1 - ph) / (64'd1 << 19));
        i = int'(ph / (64'd1 << 22));
        v = 2047.0 * $sin(2.0 * PI * (i + 0.5) / 1024.0);
        e.sin_v = 2048 + ((v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5));
        return e;
    endfunction

    // Drive one edge's inputs, predict the outputs after that edge, wait it out.
    task automatic step(input logic r, input logic [PW-1:0] f, input logic [PW-1:0] p,
                        input string tag);
        exp_t e;
        reset    = r;
        fre_word = f;
        pha_word = p;
        if (!r) begin
            e.sin_v = 2048;
            e.tri_v = 0;
            e.saw_v = 0;
            e.tag   = tag;
            m_acc   = 0;
            m_ph    = 0;
        end else begin
            e     = wave_of(m_ph, tag);
            m_ph  = (m_acc + longint'(p)) % MOD;
            m_acc = (m_acc + longint'(f)) % MOD;
        end
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
    endtask

    // Same as step, but the expected outputs are fixed numbers rather than model output.
    task automatic step_known(input logic [PW-1:0] f, input logic [PW-1:0] p, input string tag,
                              input int s, input int t, input int w);
        exp_t e;
        reset    = 1'b1;
        fre_word = f;
        pha_word = p;
        m_ph     = (m_acc + longint'(p)) % MOD;
        m_acc    = (m_acc + longint'(f)) % MOD;
        e.sin_v  = s;
        e.tri_v  = t;
        e.saw_v  = w;
        e.tag    = tag;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
    endtask

    // Monitor: every output cycle with a pending prediction is compared.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".sin"}, 32'(wave_sin), 32'(e.sin_v));
            check({e.tag, ".tri"}, 32'(wave_tri), 32'(e.tri_v));
            check({e.tag, ".saw"}, 32'(wave_saw), 32'(e.saw_v));
        end
    end

    logic [PW-1:0] pha_tab [4] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
    int sin_tab [4] = '{2054, 4095, 2042, 1};
    int tri_tab [4] = '{0, 2048, 4095, 2047};
    int saw_tab [4] = '{0, 1024, 2048, 3072};

    initial begin
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, "reset");

        // Static phases at the four quadrant boundaries.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, '0, pha_tab[i], "settle");
            step(1'b1, '0, pha_tab[i], "settle");
            step_known('0, pha_tab[i], $sformatf("static%0d", i),
                       sin_tab[i], tri_tab[i], saw_tab[i]);
        end

        // pha_word step: the new phase reaches the outputs on the second edge.
        step(1'b0, '0, '0, "reset");
        for (int i = 0; i < 3; i++) step(1'b1, '0, '0, "lat_idle");
        step_known('0, 32'h8000_0000, "lat_pha_e1", 2054, 0, 0);
        step_known('0, 32'h8000_0000, "lat_pha_e2", 2042, 4095, 2048);

        // fre_word step: the slope appears on the third edge.
        step(1'b1, '0, '0, "lat_back");
        step(1'b1, '0, '0, "lat_back");
        step(1'b1, 32'h1000_0000, '0, "lat_fre_e1");
        step(1'b1, 32'h1000_0000, '0, "lat_fre_e2");
        step(1'b1, 32'h1000_0000, '0, "lat_fre_e3");
        for (int i = 0; i < 20; i++) step(1'b1, 32'h1000_0000, '0, "lat_fre_run");

        // ~1 MHz at 100 MHz: more than a full period including the 4095->low wrap.
        step(1'b0, '0, '0, "reset");
        for (int i = 0; i < 120; i++) step(1'b1, 32'h028F_5C29, '0, "1mhz");

        // Nyquist: half a turn per cycle.
        step(1'b0, '0, '0, "reset");
        for (int i = 0; i < 12; i++) step(1'b1, 32'h8000_0000, '0, "nyquist");

        // Mid-run reset, then an identical replay of the same run.
        step(1'b0, '0, '0, "reset");
        for (int i = 0; i < 50; i++) step(1'b1, 32'h1A93_F706, 32'h4000_0000, "run_a");
        for (int i = 0; i < 5; i++)  step(1'b0, 32'h1A93_F706, 32'h4000_0000, "midreset");
        step(1'b1, 32'h1A93_F706, 32'h4000_0000, "run_b");
        step_known(32'h1A93_F706, 32'h4000_0000, "run_b_e2", 4095, 2048, 1024);
        for (int i = 0; i < 48; i++) step(1'b1, 32'h1A93_F706, 32'h4000_0000, "run_b");

        // Random words, mixed slow and fast, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [PW-1:0] f;
            logic [PW-1:0] p;
            f = ($urandom_range(0, 1) == 0) ? PW'($urandom_range(0, 32'h00FF_FFFF)) : PW'($urandom);
            p = PW'($urandom);
            if ($urandom_range(0, 39) == 0) step(1'b0, f, p, "rand_rst");
            else                            step(1'b1, f, p, "rand");
        end

        #2;
        check("drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
